fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the PC register. Each cycle it computes next-PC and the PC stall (hold) strobe.
//  Arbitrates exception, exception return (eret), branch/jump redirect and load-use hazard stalls.
//  Owns a mult/div busy counter that stalls HI/LO consumers.
//  Sits between hazard detection, ID-stage branch resolve, CP0 and the PC register / IF-ID pipe register.
// PARAMETERS
//  INIT_ADDR    32'h0000_3000  PC value after reset (must match the PC register reset value)
//  EXC_VECTOR   32'h0000_4180  exception entry address
//  MULT_CYCLES  5              mult latency, in busy cycles
//  DIV_CYCLES   32             div latency, in busy cycles
//  CNT_W        6              busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
// PORTS
//  clock         in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-high
//  pc_in         in   32  current PC register value
//  load_use_hz   in   1   ID-stage load-use hazard
//  md_start      in   1   EX issues mult/div this cycle
//  md_is_div     in   1   qualifies md_start: 1 = div, 0 = mult
//  md_use        in   1   ID instruction reads HI/LO or issues a mult/div
//  br_taken      in   1   ID-resolved branch/jump taken
//  br_target     in   32  redirect target
//  exc_req       in   1   exception request from CP0
//  exc_ret       in   1   eret in ID
//  epc           in   32  return address for eret
//  npc_out       out  32  next PC, to the PC register
//  pc_stall      out  1   1 = PC register holds its value
//  if_id_flush   out  1   clear IF/ID at the next edge
//  id_ex_bubble  out  1   insert a NOP into ID/EX at the next edge
//  md_busy       out  1   mult/div in flight (registered)
//  exc_ack       out  1   one-cycle pulse when an exception redirect is taken
// BEHAVIOUR
//  Reset (async clear): state=RUN, cnt=0, md_busy=0.
//   Combinational outputs while in reset: npc_out=pc_in+4; pc_stall, if_id_flush, id_ex_bubble and exc_ack all 0.
//  FSM states: RUN and EXC_FLUSH.
//   RUN -> EXC_FLUSH when exc_req is taken.
//   EXC_FLUSH -> RUN unconditionally after 1 cycle.
//   In EXC_FLUSH, exc_req is ignored (blocks a double trap from a younger instruction). Other rules still apply.
//  Outputs are combinational from state + inputs, zero latency. Priority, highest first:
//   1 exc_req (RUN only): npc=EXC_VECTOR, if_id_flush=1, id_ex_bubble=1, exc_ack=1, pc_stall=0; clears cnt and md_busy at the edge.
//   2 exc_ret: npc={epc[31:2],2'b00}, if_id_flush=1, pc_stall=0.
//   3 load_use_hz | (md_use & md_busy): pc_stall=1, id_ex_bubble=1, no flush. A simultaneous br_taken is ignored and re-evaluated next cycle.
//   4 br_taken: npc={br_target[31:2],2'b00}, if_id_flush per DELAY_SLOT_EN.
//   5 otherwise: npc=pc_in+4.
//  Arithmetic: pc_in+4 is modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000. Targets are forced word-aligned.
//  Busy counter:
//   md_start sampled while cnt==0 loads cnt=(md_is_div ? DIV_CYCLES : MULT_CYCLES).
//   cnt decrements by 1 each cycle; md_busy is registered (cnt!=0).
//   md_busy is high for exactly N cycles after the sampling edge.
//   md_start while md_busy=1 is ignored; no reload.
//  Reset asserted mid-stall or mid-flush: immediate return to reset values; no pending redirect survives.
// CONFIGURATION
//  DELAY_SLOT_EN defined: branch/jump asserts no if_id_flush; the delay-slot instruction proceeds.
//  DELAY_SLOT_EN undefined: br_taken asserts if_id_flush=1.
//  Exceptions and eret flush in both builds.
// STRUCTURE
//  Shared package mips_pkg:
//   fc_state_t enum {FC_RUN, FC_EXC_FLUSH}
//   INIT_ADDR and EXC_VECTOR constants
//   MULT_CYCLES and DIV_CYCLES constants
//  Sub-module md_busy_counter: cnt register, load/decrement/clear logic, md_busy output.
//  fetch_ctrl keeps the FSM and the priority mux.
// TESTING
//  1 Async reset pulse mid-cycle with pc_in=0x3000 -> immediately md_busy=0, pc_stall=0, npc_out=0x3004, FSM=RUN.
//  2 load_use_hz=1 for 1 cycle with pc_in=0x3010 and br_taken=1 -> pc_stall=1, id_ex_bubble=1, if_id_flush=0. Next cycle, br_taken alone -> npc=br_target.
//  3 md_start with md_is_div=1, then md_use held high -> md_busy high 32 cycles, pc_stall high 32 cycles. pc_stall=0 in the first cycle md_busy=0. A second md_start mid-way does not extend busy.
//  4 br_taken with br_target=0x3103 -> npc_out=0x3100; if_id_flush=1 (0 with DELAY_SLOT_EN).
//  5 exc_req during the md stall -> npc=0x4180, exc_ack=1 for 1 cycle, md_busy=0 next cycle. exc_req held next cycle -> ignored, npc=pc_in+4.
//  6 pc_in=0xFFFF_FFFC, no events -> npc_out=0x0000_0000. exc_ret with epc=0x3204 -> npc=0x3204, if_id_flush=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch sequencer: FSM state type, reset and
// exception addresses, and mult/div latencies.
package mips_pkg;

  // Fetch controller FSM: normal flow, or the one cycle after a trap redirect.
  typedef enum logic {
    FC_RUN       = 1'b0,
    FC_EXC_FLUSH = 1'b1
  } fc_state_t;

  // PC after reset. The PC register owns the reset value; it is kept here so
  // both sides read the same constant.
  localparam logic [31:0] INIT_ADDR   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;

  // Mult/div latencies in busy cycles, and a counter wide enough for both.
  localparam int          MULT_CYCLES = 5;
  localparam int          DIV_CYCLES  = 32;
  localparam int          CNT_W       = 6;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy counter. A start seen while idle loads the operation latency;
// the count then runs down by one per cycle. md_busy is a flop that is high
// for exactly N cycles after the sampling edge. A clear (exception) empties
// the counter at the next edge and wins over a simultaneous start.
import mips_pkg::*;

module md_busy_counter #(
  parameter int MULT_N = MULT_CYCLES,
  parameter int DIV_N  = DIV_CYCLES,
  parameter int W      = CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic         busy_reg;

  // Next count: clear beats load; load only when idle; otherwise run down.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (cnt_reg == '0) begin
      if (md_start) begin
        cnt_next = md_is_div ? W'(DIV_N) : W'(MULT_N);
      end
    end else begin
      cnt_next = cnt_reg - W'(1);
    end
  end

  // Counter and busy flag registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      busy_reg <= (cnt_next != '0);
    end
  end

  assign md_busy = busy_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: computes next-PC and the PC hold strobe each cycle,
// arbitrating exception, eret, load-use / HI-LO stalls and branch redirects.
// Build option: define DELAY_SLOT_EN to let the branch delay-slot instruction
// proceed (no IF/ID flush on a taken branch). Default build flushes it.
import mips_pkg::*;

module fetch_ctrl #(
  parameter logic [31:0] EXC_VEC  = EXC_VECTOR,
  parameter int          MULT_N   = MULT_CYCLES,
  parameter int          DIV_N    = DIV_CYCLES,
  parameter int          CNT_BITS = CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        load_use_hz,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        md_use,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        exc_ret,
  input  logic [31:0] epc,
  output logic [31:0] npc_out,
  output logic        pc_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        md_busy,
  output logic        exc_ack
);

`ifdef DELAY_SLOT_EN
  localparam logic BR_FLUSH = 1'b0;
`else
  localparam logic BR_FLUSH = 1'b1;
`endif

  fc_state_t state_reg;
  fc_state_t state_next;
  logic      exc_take;
  logic      stall_cond;

  assign stall_cond = load_use_hz | (md_use & md_busy);

  md_busy_counter #(
    .MULT_N (MULT_N),
    .DIV_N  (DIV_N),
    .W      (CNT_BITS)
  ) u_md_busy_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (exc_take),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy)
  );

  // State register; reset drops straight back to RUN, discarding any flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= FC_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and the prioritised redirect/stall mux. While reset is held
  // every strobe is forced low and the PC simply advances.
  always_comb begin
    state_next   = state_reg;
    npc_out      = pc_in + 32'd4;
    pc_stall     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    exc_ack      = 1'b0;
    exc_take     = 1'b0;
    if (!reset) begin
      if (exc_req && (state_reg == FC_RUN)) begin
        // Trap: redirect, squash IF/ID and ID/EX, kill any mult/div in flight.
        exc_take     = 1'b1;
        state_next   = FC_EXC_FLUSH;
        npc_out      = EXC_VEC;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        exc_ack      = 1'b1;
      end else begin
        // The flush cycle lasts exactly one cycle; exc_req is ignored in it.
        if (state_reg == FC_EXC_FLUSH) begin
          state_next = FC_RUN;
        end
        if (exc_ret) begin
          npc_out     = word_align(epc);
          if_id_flush = 1'b1;
        end else if (stall_cond) begin
          // Hold the PC; a coincident branch is re-resolved next cycle.
          pc_stall     = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (br_taken) begin
          npc_out     = word_align(br_target);
          if_id_flush = BR_FLUSH;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. Inputs change 1 time unit
// after a rising edge; combinational outputs are checked 1 unit later.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        load_use_hz;
  logic        md_start;
  logic        md_is_div;
  logic        md_use;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        exc_ret;
  logic [31:0] epc;
  logic [31:0] npc_out;
  logic        pc_stall;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        md_busy;
  logic        exc_ack;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef DELAY_SLOT_EN
  localparam logic EXP_BR_FLUSH = 1'b0;
`else
  localparam logic EXP_BR_FLUSH = 1'b1;
`endif

  fetch_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .pc_in        (pc_in),
    .load_use_hz  (load_use_hz),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .md_use       (md_use),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .exc_ret      (exc_ret),
    .epc          (epc),
    .npc_out      (npc_out),
    .pc_stall     (pc_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .md_busy      (md_busy),
    .exc_ack      (exc_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_in = 32'h3000; load_use_hz = 0; md_start = 0; md_is_div = 0;
    md_use = 0; br_taken = 0; br_target = 0; exc_req = 0; exc_ret = 0; epc = 0;
    #2;
    chk("rst_npc", npc_out, 32'h3004);
    chk("rst_busy", md_busy, 0);
    chk("rst_stall", pc_stall, 0);
    chk("rst_flush", if_id_flush, 0);
    // Requests during reset must not produce strobes.
    exc_req = 1; load_use_hz = 1; br_taken = 1; br_target = 32'h5000;
    #1;
    chk("rst_ack_gated", exc_ack, 0);
    chk("rst_stall_gated", pc_stall, 0);
    chk("rst_npc_gated", npc_out, 32'h3004);
    chk("rst_bubble_gated", id_ex_bubble, 0);
    exc_req = 0; load_use_hz = 0; br_taken = 0;
    @(negedge clock);
    reset = 0;

    // Test 1: async reset mid-stall clears md_busy immediately.
    tick(); md_start = 1; md_is_div = 1;
    tick(); md_start = 0; md_use = 1;
    #1;
    chk("t1_busy_pre", md_busy, 1);
    chk("t1_stall_pre", pc_stall, 1);
    #1 reset = 1;
    #1;
    chk("t1_busy_rst", md_busy, 0);
    chk("t1_stall_rst", pc_stall, 0);
    chk("t1_npc_rst", npc_out, 32'h3004);
    reset = 0; md_use = 0;
    // FSM: trap, then hold exc_req in the flush cycle, reset mid-cycle.
    tick(); exc_req = 1;
    #1;
    chk("t1_ack_first", exc_ack, 1);
    chk("t1_npc_exc", npc_out, 32'h4180);
    tick();
    #1;
    chk("t1_ack_ignored", exc_ack, 0);
    #1 reset = 1;
    #1 reset = 0;
    #1;
    chk("t1_ack_after_rst", exc_ack, 1);
    exc_req = 0;
    tick();

    // Test 2: load-use hazard masks a simultaneous branch.
    tick(); pc_in = 32'h3010; load_use_hz = 1; br_taken = 1; br_target = 32'h3200;
    #1;
    chk("t2_stall", pc_stall, 1);
    chk("t2_bubble", id_ex_bubble, 1);
    chk("t2_noflush", if_id_flush, 0);
    tick(); load_use_hz = 0;
    #1;
    chk("t2_br_npc", npc_out, 32'h3200);
    chk("t2_br_stall", pc_stall, 0);
    chk("t2_br_flush", if_id_flush, EXP_BR_FLUSH);

    // Test 4: branch target forced to word alignment.
    tick(); br_target = 32'h3103;
    #1;
    chk("t4_npc", npc_out, 32'h3100);
    chk("t4_flush", if_id_flush, EXP_BR_FLUSH);
    chk("t4_bubble", id_ex_bubble, 0);
    br_taken = 0;

    // Test 3: div busy for 32 cycles; a second start mid-way is ignored.
    tick(); md_start = 1; md_is_div = 1;
    #1;
    chk("t3_busy_idle", md_busy, 0);
    tick(); md_start = 0; md_use = 1;
    for (int i = 0; i < 32; i++) begin
      md_start = (i == 10);
      #1;
      chk($sformatf("t3_busy_c%0d", i), md_busy, 1);
      chk($sformatf("t3_stall_c%0d", i), pc_stall, 1);
      tick();
    end
    md_start = 0;
    #1;
    chk("t3_busy_end", md_busy, 0);
    chk("t3_stall_end", pc_stall, 0);
    md_use = 0;

    // Test 5: exception during a mult stall.
    tick(); md_start = 1; md_is_div = 0;
    tick(); md_start = 0; md_use = 1;
    #1;
    chk("t5_busy", md_busy, 1);
    chk("t5_stall", pc_stall, 1);
    tick(); exc_req = 1; pc_in = 32'h3020;
    #1;
    chk("t5_npc_exc", npc_out, 32'h4180);
    chk("t5_ack", exc_ack, 1);
    chk("t5_flush", if_id_flush, 1);
    chk("t5_bubble", id_ex_bubble, 1);
    chk("t5_stall_exc", pc_stall, 0);
    tick();
    #1;
    chk("t5_busy_cleared", md_busy, 0);
    chk("t5_ack_held", exc_ack, 0);
    chk("t5_npc_held", npc_out, 32'h3024);
    chk("t5_stall_after", pc_stall, 0);
    tick(); exc_req = 0; md_use = 0;

    // Test 6: PC wrap, then eret with alignment and priority over stall.
    tick(); pc_in = 32'hFFFF_FFFC;
    #1;
    chk("t6_wrap", npc_out, 32'h0000_0000);
    exc_ret = 1; epc = 32'h3204;
    #1;
    chk("t6_eret_npc", npc_out, 32'h3204);
    chk("t6_eret_flush", if_id_flush, 1);
    chk("t6_eret_stall", pc_stall, 0);
    epc = 32'h3207; load_use_hz = 1;
    #1;
    chk("t6_eret_align", npc_out, 32'h3204);
    chk("t6_eret_over_hz", pc_stall, 0);
    exc_ret = 0; load_use_hz = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
